// File: rtl/lock_key_sender_if.sv
// Handshake bundle between a lock_key_sender and its surroundings: the
// programming/control port on one side and the lock's code/unlocked pair
// on the other. The sender is the slave of the host-facing controls.
interface lock_key_sender_if #(
  parameter int CODE_W    = 4,
  parameter int DEPTH     = 8,
  parameter int MAX_TRIES = 3
);
  logic                           prog_en;
  logic [$clog2(DEPTH)-1:0]       prog_addr;
  logic [CODE_W-1:0]              prog_code;
  logic [$clog2(DEPTH):0]         seq_len;
  logic                           start;
  logic                           unlocked;
  logic [CODE_W-1:0]              code;
  logic                           code_valid;
  logic                           busy;
  logic                           done;
  logic                           success;
  logic [$clog2(MAX_TRIES+1)-1:0] tries;

  // Host / harness side: programs slots, kicks runs, plays the lock.
  modport master (
    output prog_en, prog_addr, prog_code, seq_len, start, unlocked,
    input  code, code_valid, busy, done, success, tries
  );

  // Sender side.
  modport slave (
    input  prog_en, prog_addr, prog_code, seq_len, start, unlocked,
    output code, code_valid, busy, done, success, tries
  );
endinterface

// File: rtl/lock_key_sender.sv
// Programmable code-sequence transmitter for a combination lock. Holds up
// to DEPTH codes, replays the first seq_len of them one per cycle on start,
// then waits WAIT_CYCLES for the lock to open, retrying up to MAX_TRIES
// attempts with a single IDLE_CODE gap cycle between attempts.
module lock_key_sender #(
  parameter int                 CODE_W      = 4,
  parameter int                 DEPTH       = 8,
  parameter int                 WAIT_CYCLES = 4,
  parameter int                 MAX_TRIES   = 3,
  parameter logic [CODE_W-1:0]  IDLE_CODE   = '0
) (
  input  logic             clk,
  input  logic             reset,
  lock_key_sender_if.slave bus
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LEN_W  = IDX_W + 1;
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int WCNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_GAP
  } state_t;

  state_t            state;
  logic [CODE_W-1:0] mem  [DEPTH];
  // Copy of mem taken when a run starts, so a write landing in the same
  // cycle as start cannot leak into the codes of that run.
  logic [CODE_W-1:0] snap [DEPTH];
  logic [LEN_W-1:0]  len;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  next_idx;
  logic [WCNT_W-1:0] wcnt;

  logic len_ok;
  logic prog_ok;
  logic last_code;
  logic wait_over;
  logic last_try;

  assign len_ok    = (bus.seq_len != '0) && (32'(bus.seq_len) <= DEPTH);
  assign prog_ok   = bus.prog_en && (32'(bus.prog_addr) < DEPTH);
  assign next_idx  = idx + IDX_W'(1);
  assign last_code = ({1'b0, idx} == (len - LEN_W'(1)));
  assign wait_over = (wcnt == WCNT_W'(WAIT_CYCLES - 1));
  assign last_try  = (bus.tries == TRY_W'(MAX_TRIES));

  // Sequencer FSM: storage, replay, wait window, retry and result reporting.
  // NOTE: every register here is assigned with <= so all reads in this block
  // see the pre-edge values; that is what makes snap <= mem capture the old
  // contents when prog_en and start coincide.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the code store is built from flops and is cleared on reset so a
      // run launched straight after reset replays all-zero codes, not junk.
      mem            <= '{default: '0};
      snap           <= '{default: '0};
      state          <= S_IDLE;
      len            <= '0;
      idx            <= '0;
      wcnt           <= '0;
      bus.code       <= IDLE_CODE;
      bus.code_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.success    <= 1'b0;
      bus.tries      <= '0;
    end else begin
      bus.done <= 1'b0;

      if (state != S_IDLE && bus.unlocked) begin
        // Lock opened: finish at once, keeping the current attempt number.
        state          <= S_IDLE;
        bus.code       <= IDLE_CODE;
        bus.code_valid <= 1'b0;
        bus.busy       <= 1'b0;
        bus.done       <= 1'b1;
        bus.success    <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            if (prog_ok) begin
              mem[bus.prog_addr] <= bus.prog_code;
            end
            if (bus.start) begin
              if (len_ok) begin
                snap           <= mem;
                len            <= bus.seq_len;
                idx            <= '0;
                bus.tries      <= TRY_W'(1);
                bus.success    <= 1'b0;
                bus.code       <= mem[0];
                bus.code_valid <= 1'b1;
                bus.busy       <= 1'b1;
                state          <= S_SEND;
              end else begin
                // Unusable length: report an immediate, empty failure.
                bus.done    <= 1'b1;
                bus.success <= 1'b0;
                bus.tries   <= '0;
              end
            end
          end

          S_SEND: begin
            if (last_code) begin
              wcnt           <= '0;
              bus.code       <= IDLE_CODE;
              bus.code_valid <= 1'b0;
              state          <= S_WAIT;
            end else begin
              idx      <= next_idx;
              bus.code <= snap[next_idx];
            end
          end

          S_WAIT: begin
            if (!wait_over) begin
              wcnt <= wcnt + WCNT_W'(1);
            end else if (last_try) begin
              bus.busy    <= 1'b0;
              bus.done    <= 1'b1;
              bus.success <= 1'b0;
              state       <= S_IDLE;
            end else begin
              state <= S_GAP;
            end
          end

          S_GAP: begin
            idx            <= '0;
            bus.tries      <= bus.tries + TRY_W'(1);
            bus.code       <= snap[0];
            bus.code_valid <= 1'b1;
            state          <= S_SEND;
          end

          default: begin
            state          <= S_IDLE;
            bus.code       <= IDLE_CODE;
            bus.code_valid <= 1'b0;
            bus.busy       <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lock_key_sender.sv
// Self-checking bench for lock_key_sender: a hand-computed vector table,
// a few multi-cycle corner sequences and randomized runs compared against a
// trace model built from the attempt/gap arithmetic of the sequencer.
module tb_lock_key_sender;

  localparam int CODE_W      = 4;
  localparam int DEPTH       = 8;
  localparam int WAIT_CYCLES = 4;
  localparam int MAX_TRIES   = 3;
  localparam int IDLE_CODE   = 0;
  localparam int AW          = $clog2(DEPTH);
  localparam int LW          = AW + 1;

  logic clk = 1'b0;
  logic reset;

  lock_key_sender_if #(.CODE_W(CODE_W), .DEPTH(DEPTH), .MAX_TRIES(MAX_TRIES)) bus ();

  lock_key_sender #(
    .CODE_W     (CODE_W),
    .DEPTH      (DEPTH),
    .WAIT_CYCLES(WAIT_CYCLES),
    .MAX_TRIES  (MAX_TRIES),
    .IDLE_CODE  (CODE_W'(IDLE_CODE))
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [CODE_W-1:0] ref_mem [DEPTH];

  typedef struct {
    string name;
    int    len;
    int    unlock_at;   // trace index where the lock reports open; large = never
    int    exp_done;    // trace index of the done pulse
    bit    exp_succ;
    int    exp_tries;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_out(input string name, input int exp_code, input int exp_cv,
                           input int exp_busy, input int exp_done, input int exp_succ,
                           input int exp_tries);
    check({name, ":code"},       32'(bus.code),       32'(exp_code));
    check({name, ":code_valid"}, 32'(bus.code_valid), 32'(exp_cv));
    check({name, ":busy"},       32'(bus.busy),       32'(exp_busy));
    check({name, ":done"},       32'(bus.done),       32'(exp_done));
    check({name, ":success"},    32'(bus.success),    32'(exp_succ));
    check({name, ":tries"},      32'(bus.tries),      32'(exp_tries));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input int addr, input int val);
    bus.prog_en   = 1'b1;
    bus.prog_addr = AW'(addr);
    bus.prog_code = CODE_W'(val);
    ref_mem[addr] = CODE_W'(val);
    tick();
    bus.prog_en = 1'b0;
  endtask

  // Reference: a run is MAX_TRIES attempts of (len codes, WAIT_CYCLES idle,
  // one gap) with the final gap dropped. An open lock seen at trace index k
  // ends the run with done at k+1, on the attempt that index belongs to.
  function automatic void model(input int len, input int unlock_at, output int done_idx,
                                output bit succ, output int n_tries);
    int period;
    int total;
    if (len < 1 || len > DEPTH) begin
      done_idx = 0;
      succ     = 1'b0;
      n_tries  = 0;
      return;
    end
    period = len + WAIT_CYCLES + 1;
    total  = MAX_TRIES * period - 1;
    if (unlock_at < total) begin
      done_idx = unlock_at + 1;
      succ     = 1'b1;
      n_tries  = unlock_at / period + 1;
    end else begin
      done_idx = total;
      succ     = 1'b0;
      n_tries  = MAX_TRIES;
    end
  endfunction

  // Launches one run and checks every cycle of it. wr_addr >= 0 writes a slot
  // in the start cycle; poke drives start and prog_en while the run is busy.
  task automatic run(input string name, input int len, input int unlock_at,
                     input int exp_done, input bit exp_succ, input int exp_tries,
                     input int wr_addr, input int wr_val, input bit poke);
    logic [CODE_W-1:0] snap [DEPTH];
    int period;
    int pos;
    string tag;
    snap   = ref_mem;
    period = len + WAIT_CYCLES + 1;
    bus.seq_len = LW'(len);
    bus.start   = 1'b1;
    if (wr_addr >= 0) begin
      bus.prog_en      = 1'b1;
      bus.prog_addr    = AW'(wr_addr);
      bus.prog_code    = CODE_W'(wr_val);
      ref_mem[wr_addr] = CODE_W'(wr_val);
    end
    tick();
    bus.start   = 1'b0;
    bus.prog_en = 1'b0;
    for (int i = 0; i <= exp_done; i++) begin
      tag = $sformatf("%s[%0d]", name, i);
      if (i == exp_done) begin
        check_out(tag, IDLE_CODE, 0, 0, 1, int'(exp_succ), exp_tries);
      end else begin
        pos = i % period;
        if (pos < len) check_out(tag, int'(snap[pos]), 1, 1, 0, 0, i / period + 1);
        else           check_out(tag, IDLE_CODE, 0, 1, 0, 0, i / period + 1);
      end
      bus.unlocked = (i == unlock_at) && (i < exp_done);
      if (poke && i == 1) begin
        bus.start     = 1'b1;
        bus.prog_en   = 1'b1;
        bus.prog_addr = '0;
        bus.prog_code = ~ref_mem[0];
      end else begin
        bus.start   = 1'b0;
        bus.prog_en = 1'b0;
      end
      if (i < exp_done) tick();
    end
    bus.unlocked = 1'b0;
    tick();
    check_out({name, ":after"}, IDLE_CODE, 0, 0, 0, int'(exp_succ), exp_tries);
  endtask

  initial begin
    int d;
    int t;
    bit s;
    int len;
    int ua;
    int wa;

    vecs[0] = '{"unlock_after_last", 4,   4,  5, 1'b1, 1};
    vecs[1] = '{"never_unlock",      4, 999, 26, 1'b0, 3};
    vecs[2] = '{"unlock_try2",       4,  13, 14, 1'b1, 2};
    vecs[3] = '{"len_zero",          0, 999,  0, 1'b0, 0};
    vecs[4] = '{"len_nine",          9, 999,  0, 1'b0, 0};
    vecs[5] = '{"unlock_in_send",    1,   0,  1, 1'b1, 1};
    vecs[6] = '{"unlock_in_gap",     4,   8,  9, 1'b1, 1};
    vecs[7] = '{"unlock_last_wait",  4,  25, 26, 1'b1, 3};
    vecs[8] = '{"full_depth_never",  8, 999, 38, 1'b0, 3};

    bus.prog_en   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_code = '0;
    bus.seq_len   = '0;
    bus.start     = 1'b0;
    bus.unlocked  = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) check_out($sformatf("idle[%0d]", i), IDLE_CODE, 0, 0, 0, 0, 0);

    prog(0, 3);
    prog(1, 7);
    prog(2, 1);
    prog(3, 9);

    for (int v = 0; v < 9; v++)
      run(vecs[v].name, vecs[v].len, vecs[v].unlock_at, vecs[v].exp_done,
          vecs[v].exp_succ, vecs[v].exp_tries, -1, 0, 1'b0);

    // start and prog_en while busy must not disturb the run or slot 0.
    run("busy_poke", 4, 4, 5, 1'b1, 1, -1, 0, 1'b1);
    run("after_poke", 4, 4, 5, 1'b1, 1, -1, 0, 1'b0);

    // Same-cycle write of slot 1: this run sends the old 7, the next sends 12.
    run("start_with_write", 4, 4, 5, 1'b1, 1, 1, 12, 1'b0);
    run("after_write", 4, 4, 5, 1'b1, 1, -1, 0, 1'b0);

    // Reset while the second code is on the bus.
    bus.seq_len = LW'(4);
    bus.start   = 1'b1;
    tick();
    bus.start = 1'b0;
    check_out("mid_reset[0]", int'(ref_mem[0]), 1, 1, 0, 0, 1);
    tick();
    check_out("mid_reset[1]", int'(ref_mem[1]), 1, 1, 0, 0, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_out("mid_reset:cleared", IDLE_CODE, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    tick();
    check_out("mid_reset:no_done", IDLE_CODE, 0, 0, 0, 0, 0);
    run("post_reset_zeros", 4, 3, 4, 1'b1, 1, -1, 0, 1'b0);

    // Randomized runs against the trace model.
    for (int r = 0; r < 25; r++) begin
      for (int w = 0; w < 3; w++) prog($urandom_range(0, DEPTH - 1), $urandom_range(0, 15));
      len = $urandom_range(0, 9);
      ua  = $urandom_range(0, MAX_TRIES * (len + WAIT_CYCLES + 1) + 1);
      wa  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1)) : -1;
      model(len, ua, d, s, t);
      run($sformatf("rand%0d", r), len, ua, d, s, t, wa, $urandom_range(0, 15), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
